// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: controller state
// encoding and the default pattern/counter widths.
package seq_det_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when a requested pattern length can be held by a PAT_W-bit window.
    function automatic logic len_legal(input int len, input int pat_w);
        return (len >= 1) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_matcher.sv
// Shift window, fill tracking and pattern compare for the sequence detector.
// hit is combinational and describes the bit being shifted in this cycle, so
// the controller can register it into a match pulse one cycle later.
module seq_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(DEF_PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] win;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] win_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [PAT_W-1:0] mask;

    // Post-shift window/fill and the masked compare against the low len bits.
    always_comb begin
        win_shift = {win[PAT_W-2:0], in};
        fill_inc  = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
        mask      = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = in_valid && (fill_inc >= len) &&
              ((win_shift & mask) == (pattern & mask));
    end

    // Window state: cleared on reset/start, shifts on each qualified bit.
    // A non-overlapping match empties the fill so the next match needs a
    // fully fresh set of len bits.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win  <= '0;
            fill <= '0;
        end else if (in_valid) begin
            win  <= win_shift;
            fill <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector controller: configuration handshake, the
// IDLE/ARMED/RUN/DONE state machine and the saturating match counter.
// The shift window and comparator live in seq_matcher.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PAT_W-1:0]       cfg_pattern,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic                   cfg_overlap,
    input  logic [CNT_W-1:0]       cfg_target,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in,
    input  logic                   in_valid,
    output logic                   match,
    output logic [CNT_W-1:0]       match_count,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int               LEN_W   = $clog2(PAT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;

    logic             cfg_ok;
    logic             start_go;
    logic             run_bit;
    logic             hit;
    logic [CNT_W-1:0] count_inc;
    logic             reach;

    // Decode of this cycle's requests against the current state. abort
    // suppresses everything else; in DONE a pending cfg takes precedence
    // over start.
    always_comb begin
        cfg_ok    = len_legal(int'(cfg_len), PAT_W);
        start_go  = !abort && start &&
                    ((state == ARMED) || ((state == DONE) && !cfg_valid));
        run_bit   = in_valid && !abort && (state == RUN);
        count_inc = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);
        reach     = (target_q != '0) && (count_inc == target_q);
    end

    seq_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_go),
        .in       (in),
        .in_valid (run_bit),
        .pattern  (pattern_q),
        .len      (len_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    // Controller FSM with registered status outputs and config latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!abort && cfg_valid) begin
                        if (cfg_ok) begin
                            pattern_q <= cfg_pattern;
                            len_q     <= cfg_len;
                            overlap_q <= cfg_overlap;
                            target_q  <= cfg_target;
                            state     <= ARMED;
                            cfg_ready <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end else if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        match_count <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (hit) begin
                        match       <= 1'b1;
                        match_count <= count_inc;
                        if (reach) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (cfg_valid) begin
                        if (cfg_ok) begin
                            pattern_q <= cfg_pattern;
                            len_q     <= cfg_len;
                            overlap_q <= cfg_overlap;
                            target_q  <= cfg_target;
                            state     <= ARMED;
                            done      <= 1'b0;
                            cfg_ready <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else if (start) begin
                        state       <= RUN;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        cfg_ready   <= 1'b0;
                        match_count <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
